// File: rtl/pe_stream_feeder.sv
// Upstream feeder for the first PE of the systolic float32 multiply chain.
// Buffers one B vector and an A matrix, preloads B, then streams A row by row.
module pe_stream_feeder #(
  parameter int N    = 4,
  parameter int ROWS = 2,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [AW-1:0]        wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 start,
  input  logic                 input_ack,
  output logic [31:0]          a,
  output logic [31:0]          b,
  output logic                 stb,
  output logic                 input_b_valid,
  output logic                 mem_select,
  output logic [$clog2(N)-1:0] addr,
  output logic                 row_last,
  output logic                 busy,
  output logic                 done
);

  localparam int LN = $clog2(N);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, PRE_B, STREAM_A, FINISH} state_t;

  state_t        state_q, state_d;
  logic [LN-1:0] k_q, k_d;
  logic [RW-1:0] row_q, row_d;

  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          stb_q, stb_d, ibv_q, ibv_d, msel_q, msel_d;
  logic [LN-1:0] addr_q, addr_d;
  logic          rl_q, rl_d, busy_q, busy_d, done_q, done_d;

  logic [31:0]   a_mem [2**AW];
  logic [31:0]   b_mem [N];

  logic          wr_ok, xfer;
  logic [AW-1:0] a_idx;
  logic [31:0]   b_rd;

  // Buffers are only writable while idle, so a run always sees frozen data.
  assign wr_ok = wr_en && (state_q == IDLE);
  assign xfer  = stb_q && input_ack;

  // NOTE: storage arrays carry no reset; their contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) b_mem[wr_addr[LN-1:0]] <= wr_data;
      else        a_mem[wr_addr]         <= wr_data;
    end
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRE_B;
          k_d     = '0;
          row_d   = '0;
        end
      end
      PRE_B: begin
        if (xfer) begin
          if (k_q == LN'(N-1)) begin
            k_d     = '0;
            state_d = STREAM_A;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      STREAM_A: begin
        if (xfer) begin
          if (k_q == LN'(N-1)) begin
            k_d = '0;
            if (row_q == RW'(ROWS-1)) begin
              row_d   = '0;
              state_d = FINISH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned
  // with it; a write landing in the same cycle as start is forwarded into B.
  always_comb begin
    a_idx = AW'({row_d, k_d});
    b_rd  = b_mem[k_d];
    if (wr_ok && wr_sel && (wr_addr[LN-1:0] == k_d)) b_rd = wr_data;

    a_d    = '0;
    b_d    = '0;
    stb_d  = 1'b0;
    ibv_d  = 1'b0;
    msel_d = 1'b0;
    addr_d = '0;
    rl_d   = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      PRE_B: begin
        stb_d  = 1'b1;
        ibv_d  = 1'b1;
        msel_d = 1'b1;
        b_d    = b_rd;
        addr_d = k_d;
      end
      STREAM_A: begin
        stb_d  = 1'b1;
        a_d    = a_mem[a_idx];
        b_d    = b_rd;
        addr_d = k_d;
        rl_d   = (k_d == LN'(N-1));
      end
      FINISH:  done_d = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      stb_q   <= 1'b0;
      ibv_q   <= 1'b0;
      msel_q  <= 1'b0;
      addr_q  <= '0;
      rl_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      a_q     <= a_d;
      b_q     <= b_d;
      stb_q   <= stb_d;
      ibv_q   <= ibv_d;
      msel_q  <= msel_d;
      addr_q  <= addr_d;
      rl_q    <= rl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a             = a_q;
  assign b             = b_q;
  assign stb           = stb_q;
  assign input_b_valid = ibv_q;
  assign mem_select    = msel_q;
  assign addr          = addr_q;
  assign row_last      = rl_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Self-checking bench for pe_stream_feeder: directed scenarios plus randomized
// data and back-pressure, compared against a word-sequence reference model.
module tb_pe_stream_feeder;

  localparam int N    = 4;
  localparam int ROWS = 2;
  localparam int AW   = 3;
  localparam int LN   = $clog2(N);
  localparam int RUN_XFERS = N + ROWS * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_sel, start, input_ack;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   a, b;
  logic          stb, input_b_valid, mem_select, row_last, busy, done;
  logic [LN-1:0] addr;

  pe_stream_feeder #(.N(N), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .input_ack(input_ack), .a(a), .b(b),
    .stb(stb), .input_b_valid(input_b_valid), .mem_select(mem_select),
    .addr(addr), .row_last(row_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          addr;
    bit          ms;
    bit          ibv;
    bit          rl;
  } word_t;

  logic [31:0] a_ref [ROWS*N];
  logic [31:0] b_ref [N];
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return {a, b, 8'(addr), 2'd0, stb, busy, done, mem_select, input_b_valid, row_last};
  endfunction

  function automatic logic [79:0] word_exp(input word_t w);
    return {w.a, w.b, 8'(w.addr), 2'd0, 1'b1, 1'b1, 1'b0, w.ms, w.ibv, w.rl};
  endfunction

  task automatic write(input bit sel, input int wa, input logic [31:0] wd);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(wa); wr_data = wd;
    if (sel) b_ref[wa % N] = wd; else a_ref[wa] = wd;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // ack_mode: 0 = tied high, 1 = 1,0,0,1 pattern, 2 = random.
  task automatic run(input string tag, input int ack_mode, input int restart_c,
                     input int wr_c, input bit same_cycle_wr);
    word_t q[$];
    word_t w;
    int    xfers = 0;
    int    done_c = -1;
    bit    ack;
    @(negedge clk);
    if (same_cycle_wr) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = 32'h4080_0000;
      b_ref[0] = 32'h4080_0000;
    end
    for (int k = 0; k < N; k++) begin
      w = '{a: 32'd0, b: b_ref[k], addr: k, ms: 1'b1, ibv: 1'b1, rl: 1'b0};
      q.push_back(w);
    end
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < N; k++) begin
        w = '{a: a_ref[r*N+k], b: b_ref[k], addr: k, ms: 1'b0, ibv: 1'b0, rl: (k == N-1)};
        q.push_back(w);
      end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        done_c = c;
        break;
      end
      if (q.size() == 0) check({tag, " extra_word"}, outs(), 80'd0);
      else               check({tag, " word"}, outs(), word_exp(q[0]));
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (c % 4 == 0) || (c % 4 == 3);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      input_ack = ack;
      start = (c == restart_c);
      if (c == wr_c) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(5); wr_data = 32'hDEAD_BEEF;
      end else begin
        wr_en = 1'b0;
      end
      if (ack && stb && q.size() > 0) begin
        void'(q.pop_front());
        xfers++;
      end
      @(negedge clk);
    end
    input_ack = 1'b0; start = 1'b0; wr_en = 1'b0;
    check({tag, " done_seen"}, 80'(done_c >= 0), 80'd1);
    check({tag, " xfer_count"}, 80'(xfers), 80'(RUN_XFERS));
    check({tag, " busy_in_finish"}, 80'(busy), 80'd1);
    if (ack_mode == 0) check({tag, " done_cycle"}, 80'(done_c), 80'(RUN_XFERS));
    @(negedge clk);
    check({tag, " after_done"}, 80'({busy, done, stb}), 80'd0);
  endtask

  initial begin
    bit any_bad;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; input_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 80'd0);
    rst = 1'b0;

    // Load and run with ack tied high.
    for (int k = 0; k < N; k++) write(1'b1, k, 32'h3F80_0000);
    for (int k = 0; k < N; k++) write(1'b0, k, 32'h4000_0000);
    for (int k = 0; k < N; k++) write(1'b0, N + k, 32'h4040_0000);
    run("load_run", 0, -1, -1, 1'b0);

    // Back-pressure 1,0,0,1 with an ignored start and an ignored write mid-run.
    run("backpressure", 1, 3, 5, 1'b0);
    run("frozen_rerun", 0, -1, -1, 1'b0);

    // Reset during STREAM_A row 0, k=2.
    @(negedge clk);
    start = 1'b1; input_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_pos", 80'({addr, mem_select, stb}), 80'({LN'(2), 1'b0, 1'b1}));
    rst = 1'b1;
    @(negedge clk);
    check("mid_run_reset", outs(), 80'd0);
    rst = 1'b0; input_ack = 1'b0;
    any_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || stb || busy) any_bad = 1'b1;
    end
    check("no_done_after_reset", 80'(any_bad), 80'd0);
    run("replay_after_reset", 0, -1, -1, 1'b0);

    // Ack in idle has no effect.
    any_bad = 1'b0;
    input_ack = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (stb || busy || done) any_bad = 1'b1;
    end
    input_ack = 1'b0;
    check("idle_ack", 80'(any_bad), 80'd0);

    // Write B[0] in the same cycle as start.
    run("same_cycle_write", 0, -1, -1, 1'b1);

    // Randomized data with random back-pressure.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < N; k++) write(1'b1, k, $urandom);
      for (int k = 0; k < ROWS*N; k++) write(1'b0, k, $urandom);
      run("random_run", 2, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
